// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the LED matrix row shifter.
// Holds the FSM state encoding, the row / address widths, the counter widths
// and the default timing parameters used by matrix_row_shifter and
// matrix_sclk_gen.
package matrix_pkg;

    // Row controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    // Pixel bits per row half and row-address width.
    localparam int ROW_BITS = 32;
    localparam int ADDR_W   = 3;

    // Counter widths: bit index covers 0..31, phase covers CLK_DIV up to 15,
    // display counter covers ON_TIME up to 65535.
    localparam int BIT_IDX_W = 5;
    localparam int PHASE_W   = 4;
    localparam int DISP_W    = 16;

    // Default timing.
    localparam int CLK_DIV_DEFAULT = 2;
    localparam int ON_TIME_DEFAULT = 256;

endpackage

// File: rtl/matrix_sclk_gen.sv
// matrix_sclk_gen: panel shift-clock generator and bit counter.
// While enable is high, each bit lasts 2*CLK_DIV cycles: sclk low for the
// first CLK_DIV cycles, high for the next CLK_DIV. bit_index advances on the
// cycle sclk returns low, so data selected by bit_index is stable across every
// rising sclk. last_bit flags the final cycle of bit 31's high phase; on that
// cycle all counters wrap to zero. Dropping enable clears everything.
// Legal CLK_DIV range: 1..15.
module matrix_sclk_gen
    import matrix_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 sclk,
    output logic [BIT_IDX_W-1:0] bit_index,
    output logic                 last_bit
);

    localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST   = BIT_IDX_W'(ROW_BITS - 1);

    logic [PHASE_W-1:0]   phase_reg;
    logic                 half_reg;
    logic [BIT_IDX_W-1:0] bit_reg;

    logic phase_wrap;

    assign phase_wrap = (phase_reg == PHASE_LAST);

    // Phase, half-period and bit counters; cleared whenever shifting is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= '0;
            half_reg  <= 1'b0;
            bit_reg   <= '0;
        end else if (!enable) begin
            phase_reg <= '0;
            half_reg  <= 1'b0;
            bit_reg   <= '0;
        end else if (phase_wrap) begin
            phase_reg <= '0;
            if (half_reg) begin
                // End of the high phase: move to the next bit, wrapping after 31.
                half_reg <= 1'b0;
                bit_reg  <= (bit_reg == BIT_LAST) ? '0 : bit_reg + 1'b1;
            end else begin
                half_reg <= 1'b1;
            end
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

    assign sclk      = half_reg;
    assign bit_index = bit_reg;
    assign last_bit  = enable && half_reg && phase_wrap && (bit_reg == BIT_LAST);

endmodule

// File: rtl/matrix_row_shifter.sv
// matrix_row_shifter: HUB75-style row driver.
// Accepts one row (upper half on red, lower half on red2, row address on
// linesel) when idle, shifts 32 bits out on r1/r2 with a divided sclk, pulses
// lat for two cycles while loading addr, then enables the panel for ON_TIME
// cycles and pulses done in the last of them.
// Optional macro MATRIX_BLANK_SHIFT_EN: when defined, oe_n stays high for the
// whole SHIFT state so the panel is dark while shifting; otherwise the
// previously latched row stays visible during SHIFT.
// Legal ranges: CLK_DIV 1..15, ON_TIME 1..65535.
module matrix_row_shifter
    import matrix_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int ON_TIME = ON_TIME_DEFAULT
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ROW_BITS-1:0] red,
    input  logic [ROW_BITS-1:0] red2,
    input  logic [ADDR_W-1:0]   linesel,
    input  logic                send,
    output logic                ready,
    output logic                r1,
    output logic                r2,
    output logic                sclk,
    output logic                lat,
    output logic                oe_n,
    output logic [ADDR_W-1:0]   addr,
    output logic                done
);

    // Final display-count value, and the one before it (where done is armed).
    localparam logic [DISP_W-1:0] ON_LAST   = DISP_W'(ON_TIME - 1);
    localparam logic [DISP_W-1:0] ON_PRE    = DISP_W'(ON_TIME - 2);
    localparam logic [DISP_W-1:0] LATCH_END = DISP_W'(1);

`ifdef MATRIX_BLANK_SHIFT_EN
    localparam logic SHIFT_OE_N = 1'b1;
`else
    localparam logic SHIFT_OE_N = 1'b0;
`endif

    state_t              state_reg;
    logic [ROW_BITS-1:0] red_hold_reg;
    logic [ROW_BITS-1:0] red2_hold_reg;
    logic [ADDR_W-1:0]   line_hold_reg;
    logic [DISP_W-1:0]   disp_cnt_reg;
    logic                ready_reg;
    logic                lat_reg;
    logic                oe_n_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                done_reg;

    logic                 shift_en;
    logic [BIT_IDX_W-1:0] bit_index;
    logic                 last_bit;

    assign shift_en = (state_reg == SHIFT);

    matrix_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (shift_en),
        .sclk      (sclk),
        .bit_index (bit_index),
        .last_bit  (last_bit)
    );

    // Row FSM with registered panel controls; the display counter doubles as
    // the two-cycle latch timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            red_hold_reg  <= '0;
            red2_hold_reg <= '0;
            line_hold_reg <= '0;
            disp_cnt_reg  <= '0;
            ready_reg     <= 1'b1;
            lat_reg       <= 1'b0;
            oe_n_reg      <= 1'b1;
            addr_reg      <= '0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    lat_reg   <= 1'b0;
                    oe_n_reg  <= 1'b1;
                    done_reg  <= 1'b0;
                    if (send) begin
                        // The only cycle in which the holding registers load.
                        red_hold_reg  <= red;
                        red2_hold_reg <= red2;
                        line_hold_reg <= linesel;
                        ready_reg     <= 1'b0;
                        oe_n_reg      <= SHIFT_OE_N;
                        state_reg     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (last_bit) begin
                        state_reg    <= LATCH;
                        lat_reg      <= 1'b1;
                        oe_n_reg     <= 1'b1;
                        addr_reg     <= line_hold_reg;
                        disp_cnt_reg <= '0;
                    end
                end

                LATCH: begin
                    if (disp_cnt_reg == LATCH_END) begin
                        state_reg    <= DISPLAY;
                        lat_reg      <= 1'b0;
                        oe_n_reg     <= 1'b0;
                        disp_cnt_reg <= '0;
                        // A one-cycle display window makes its first cycle the last.
                        done_reg     <= (ON_TIME == 1);
                    end else begin
                        disp_cnt_reg <= disp_cnt_reg + 1'b1;
                    end
                end

                DISPLAY: begin
                    if (disp_cnt_reg == ON_LAST) begin
                        state_reg    <= IDLE;
                        ready_reg    <= 1'b1;
                        oe_n_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                        disp_cnt_reg <= '0;
                    end else begin
                        disp_cnt_reg <= disp_cnt_reg + 1'b1;
                        // Arm done so it is high in exactly the final display cycle.
                        done_reg     <= (disp_cnt_reg == ON_PRE);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Serial data comes straight from the holding registers; bit_index only
    // moves when sclk falls, so r1/r2 never change while sclk is high.
    assign r1 = shift_en && red_hold_reg[bit_index];
    assign r2 = shift_en && red2_hold_reg[bit_index];

    assign ready = ready_reg;
    assign lat   = lat_reg;
    assign oe_n  = oe_n_reg;
    assign addr  = addr_reg;
    assign done  = done_reg;

endmodule
